// File: rtl/board_write_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : board_write_scheduler_if
// Purpose  : Two-requester cell-write handshake bundle. Requester A is game
//            logic (reveal/flag/bomb placement). Requester B is cursor and
//            highlight logic.
// Signals  : a_/b_valid  - write request
//            a_/b_ready  - write accepted this cycle (driven by the scheduler)
//            a_/b_row    - target row
//            a_/b_col    - target column
//            a_/b_data   - cell code to store
// Modports : master - requester side
//            slave  - scheduler side
// Revision : 1.0 - initial release
// ============================================================================
interface board_write_scheduler_if #(
  parameter int ROW_W  = 3,
  parameter int COL_W  = 3,
  parameter int CELL_W = 12
);
  logic              a_valid;
  logic              a_ready;
  logic [ROW_W-1:0]  a_row;
  logic [COL_W-1:0]  a_col;
  logic [CELL_W-1:0] a_data;
  logic              b_valid;
  logic              b_ready;
  logic [ROW_W-1:0]  b_row;
  logic [COL_W-1:0]  b_col;
  logic [CELL_W-1:0] b_data;

  modport master (
    output a_valid, a_row, a_col, a_data,
    output b_valid, b_row, b_col, b_data,
    input  a_ready, b_ready
  );

  modport slave (
    input  a_valid, a_row, a_col, a_data,
    input  b_valid, b_row, b_col, b_data,
    output a_ready, b_ready
  );
endinterface
`default_nettype wire

// File: rtl/board_write_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : board_write_scheduler
// Purpose  : Owns the board cell-code store feeding the video controller.
//            It arbitrates cell writes from two requesters and commits them
//            only during vertical blanking. On request it runs a
//            one-cell-per-cycle board clear.
// Ports    : CLOCK_50   - system clock
//            reset      - asynchronous active-high reset
//            init_req   - single-cycle pulse that starts the board clear
//            vblank     - high during vertical blanking (write window)
//            req        - requester A/B handshake bundle (slave side)
//            board_flat - cell (r,c) at bits [(r*COLS+c)*CELL_W +: CELL_W]
//            busy       - high while the clear sequence runs
//            clear_done - one-cycle pulse after the last cell is cleared
// Revision : 1.0 - initial release
// ============================================================================
module board_write_scheduler #(
  parameter int                ROWS        = 8,
  parameter int                COLS        = 8,
  parameter int                CELL_W      = 12,
  parameter logic [CELL_W-1:0] HIDDEN_CODE = {CELL_W{1'b0}}
) (
  input  logic                          CLOCK_50,
  input  logic                          reset,
  input  logic                          init_req,
  input  logic                          vblank,
  board_write_scheduler_if.slave        req,
  output logic [ROWS*COLS*CELL_W-1:0]   board_flat,
  output logic                          busy,
  output logic                          clear_done
);

  localparam int NCELLS = ROWS * COLS;
  localparam int IDX_W  = $clog2(NCELLS);

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

  localparam logic GRANT_A = 1'b0;
  localparam logic GRANT_B = 1'b1;

  logic [0:0]        state;
  logic [IDX_W-1:0]  clr_idx;
  logic              last_grant;

  logic              accept;
  logic              a_fire;
  logic              b_fire;
  logic [IDX_W-1:0]  wr_addr;
  logic [CELL_W-1:0] wr_data;

  // The ready terms are combinational. Reset is folded in so that neither
  // requester sees an accept while reset is held. A tie goes to whichever
  // requester was not granted last.
  always_comb begin
    accept      = (state == ST_RUN) && vblank && !init_req && !reset;
    req.a_ready = accept && req.a_valid && (!req.b_valid || (last_grant == GRANT_B));
    req.b_ready = accept && req.b_valid && (!req.a_valid || (last_grant == GRANT_A));
    a_fire      = req.a_valid && req.a_ready;
    b_fire      = req.b_valid && req.b_ready;
    if (a_fire) begin
      wr_addr = IDX_W'(req.a_row) * IDX_W'(COLS) + IDX_W'(req.a_col);
      wr_data = req.a_data;
    end else begin
      wr_addr = IDX_W'(req.b_row) * IDX_W'(COLS) + IDX_W'(req.b_col);
      wr_data = req.b_data;
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      board_flat <= {NCELLS{HIDDEN_CODE}};
      state      <= ST_RUN;
      busy       <= 1'b0;
      clear_done <= 1'b0;
      clr_idx    <= '0;
      last_grant <= GRANT_B;
    end else begin
      clear_done <= 1'b0;
      if (state == ST_CLEAR) begin
        // One cell per cycle, independent of vblank. A repeated init_req
        // does not restart the sequence.
        board_flat[int'(clr_idx) * CELL_W +: CELL_W] <= HIDDEN_CODE;
        clr_idx <= clr_idx + IDX_W'(1);
        if (clr_idx == IDX_W'(NCELLS - 1)) begin
          state      <= ST_RUN;
          busy       <= 1'b0;
          clear_done <= 1'b1;
        end
      end else begin
        if (init_req) begin
          state   <= ST_CLEAR;
          busy    <= 1'b1;
          clr_idx <= '0;
        end else if (a_fire || b_fire) begin
          board_flat[int'(wr_addr) * CELL_W +: CELL_W] <= wr_data;
          last_grant <= a_fire ? GRANT_A : GRANT_B;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_board_write_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_board_write_scheduler
// Purpose  : Directed self-checking bench for board_write_scheduler.
//            Inputs change on the falling clock edge. Combinational readies
//            are sampled 1ns later. Registered outputs are sampled 1ns after
//            the rising edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_board_write_scheduler;

  localparam logic [11:0] HIDDEN = 12'h000;

  logic         clk;
  logic         reset;
  logic         init_req;
  logic         vblank;
  logic [767:0] board_flat;
  logic         busy;
  logic         clear_done;

  int tests = 0;
  int fails = 0;

  logic [11:0] model [64];

  board_write_scheduler_if bus ();

  board_write_scheduler dut (
    .CLOCK_50   (clk),
    .reset      (reset),
    .init_req   (init_req),
    .vblank     (vblank),
    .req        (bus),
    .board_flat (board_flat),
    .busy       (busy),
    .clear_done (clear_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [767:0] model_flat();
    logic [767:0] f;
    for (int i = 0; i < 64; i++) f[i*12 +: 12] = model[i];
    return f;
  endfunction

  task automatic model_hide_all();
    for (int i = 0; i < 64; i++) model[i] = HIDDEN;
  endtask

  task automatic idle_inputs();
    init_req    = 1'b0;
    vblank      = 1'b0;
    bus.a_valid = 1'b0;
    bus.a_row   = 3'd0;
    bus.a_col   = 3'd0;
    bus.a_data  = 12'h000;
    bus.b_valid = 1'b0;
    bus.b_row   = 3'd0;
    bus.b_col   = 3'd0;
    bus.b_data  = 12'h000;
  endtask

  // --------------------------------------------------------------------------
  task automatic test_reset();
    idle_inputs();
    reset       = 1'b1;
    vblank      = 1'b1;
    bus.a_valid = 1'b1;
    bus.b_valid = 1'b1;
    #2;
    tests++;
    if ({bus.a_ready, bus.b_ready} !== 2'b00) begin
      fails++;
      $display("FAIL reset_ready_in_reset: got %b want 00", {bus.a_ready, bus.b_ready});
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset  = 1'b0;
    vblank = 1'b0;
    #1;
    model_hide_all();
    tests++;
    if (board_flat !== model_flat()) begin
      fails++;
      $display("FAIL reset_board: got %h want %h", board_flat, model_flat());
    end
    tests++;
    if (busy !== 1'b0 || clear_done !== 1'b0) begin
      fails++;
      $display("FAIL reset_flags: got busy=%b done=%b want 0 0", busy, clear_done);
    end
    tests++;
    if ({bus.a_ready, bus.b_ready} !== 2'b00) begin
      fails++;
      $display("FAIL reset_ready_no_vblank: got %b want 00", {bus.a_ready, bus.b_ready});
    end
    bus.a_valid = 1'b0;
    bus.b_valid = 1'b0;
  endtask

  // --------------------------------------------------------------------------
  // Both valid, A targets cell 0 and B targets cell 1. Each requester moves
  // to its next data only after being granted. After reset A wins first.
  task automatic test_arbitration();
    logic [11:0] ad;
    logic [11:0] bd;
    logic        exp_a;
    ad = 12'd1;
    bd = 12'd2;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      vblank      = 1'b1;
      bus.a_valid = 1'b1; bus.a_row = 3'd0; bus.a_col = 3'd0; bus.a_data = ad;
      bus.b_valid = 1'b1; bus.b_row = 3'd0; bus.b_col = 3'd1; bus.b_data = bd;
      #1;
      exp_a = (k % 2 == 0);
      tests++;
      if ({bus.a_ready, bus.b_ready} !== {exp_a, !exp_a}) begin
        fails++;
        $display("FAIL arb_grant_%0d: got a/b=%b want %b", k,
                 {bus.a_ready, bus.b_ready}, {exp_a, !exp_a});
      end
      @(posedge clk);
      #1;
      if (exp_a) begin
        model[0] = ad;
        ad       = ad + 12'd2;
      end else begin
        model[1] = bd;
        bd       = bd + 12'd2;
      end
      tests++;
      if (board_flat !== model_flat()) begin
        fails++;
        $display("FAIL arb_board_%0d: got %h want %h", k, board_flat, model_flat());
      end
    end
    @(negedge clk);
    idle_inputs();
    tests++;
    if (board_flat[0 +: 24] !== {12'h004, 12'h003}) begin
      fails++;
      $display("FAIL arb_final: got %h want 004003", board_flat[0 +: 24]);
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_single_write();
    @(negedge clk);
    vblank      = 1'b1;
    bus.a_valid = 1'b1;
    bus.a_row   = 3'd2;
    bus.a_col   = 3'd5;
    bus.a_data  = 12'h0A3;
    #1;
    tests++;
    if ({bus.a_ready, bus.b_ready} !== 2'b10) begin
      fails++;
      $display("FAIL single_ready: got %b want 10", {bus.a_ready, bus.b_ready});
    end
    @(posedge clk);
    #1;
    model[21] = 12'h0A3;
    tests++;
    if (board_flat[21*12 +: 12] !== 12'h0A3) begin
      fails++;
      $display("FAIL single_cell21: got %h want 0a3", board_flat[21*12 +: 12]);
    end
    tests++;
    if (board_flat !== model_flat()) begin
      fails++;
      $display("FAIL single_board: got %h want %h", board_flat, model_flat());
    end
    @(negedge clk);
    idle_inputs();
  endtask

  // --------------------------------------------------------------------------
  // B alone is granted without contention, even if B was not last granted.
  task automatic test_b_only();
    @(negedge clk);
    vblank      = 1'b1;
    bus.b_valid = 1'b1;
    bus.b_row   = 3'd4;
    bus.b_col   = 3'd6;
    bus.b_data  = 12'h5C7;
    #1;
    tests++;
    if ({bus.a_ready, bus.b_ready} !== 2'b01) begin
      fails++;
      $display("FAIL b_only_ready: got %b want 01", {bus.a_ready, bus.b_ready});
    end
    @(posedge clk);
    #1;
    model[38] = 12'h5C7;
    tests++;
    if (board_flat !== model_flat()) begin
      fails++;
      $display("FAIL b_only_board: got %h want %h", board_flat, model_flat());
    end
    @(negedge clk);
    idle_inputs();
  endtask

  // --------------------------------------------------------------------------
  task automatic test_vblank_hold();
    int early_ready;
    early_ready = 0;
    @(negedge clk);
    vblank      = 1'b0;
    bus.a_valid = 1'b1;
    bus.a_row   = 3'd7;
    bus.a_col   = 3'd7;
    bus.a_data  = 12'hABC;
    for (int k = 0; k < 10; k++) begin
      #1;
      if (bus.a_ready !== 1'b0) early_ready++;
      @(negedge clk);
    end
    tests++;
    if (early_ready != 0) begin
      fails++;
      $display("FAIL vblank_hold_ready: got %0d ready cycles want 0", early_ready);
    end
    tests++;
    if (board_flat !== model_flat()) begin
      fails++;
      $display("FAIL vblank_hold_board: got %h want %h", board_flat, model_flat());
    end
    vblank = 1'b1;
    #1;
    tests++;
    if (bus.a_ready !== 1'b1) begin
      fails++;
      $display("FAIL vblank_open_ready: got %b want 1", bus.a_ready);
    end
    @(posedge clk);
    #1;
    model[63] = 12'hABC;
    tests++;
    if (board_flat[63*12 +: 12] !== 12'hABC) begin
      fails++;
      $display("FAIL vblank_write: got %h want abc", board_flat[63*12 +: 12]);
    end
    @(negedge clk);
    idle_inputs();
  endtask

  // --------------------------------------------------------------------------
  // Fill the board, then clear it while A keeps requesting. A second
  // init_req and a vblank gap fall inside the clear and must not disturb it.
  task automatic test_clear();
    int busy_cnt;
    int cd_cnt;
    int cd_at;
    int viol;
    int fill_miss;
    busy_cnt  = 0;
    cd_cnt    = 0;
    cd_at     = -1;
    viol      = 0;
    fill_miss = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      vblank      = 1'b1;
      bus.a_valid = 1'b1;
      bus.a_row   = 3'(i / 8);
      bus.a_col   = 3'(i % 8);
      bus.a_data  = 12'(i * 37 + 5);
      #1;
      if (bus.a_ready !== 1'b1) fill_miss++;
      @(posedge clk);
      model[i] = 12'(i * 37 + 5);
    end
    #1;
    tests++;
    if (fill_miss != 0 || board_flat !== model_flat()) begin
      fails++;
      $display("FAIL clear_fill: misses=%0d got %h want %h", fill_miss, board_flat, model_flat());
    end
    @(negedge clk);
    init_req    = 1'b1;
    bus.a_row   = 3'd1;
    bus.a_col   = 3'd1;
    bus.a_data  = 12'hFFF;
    #1;
    tests++;
    if (bus.a_ready !== 1'b0) begin
      fails++;
      $display("FAIL clear_init_ready: got %b want 0", bus.a_ready);
    end
    for (int k = 1; k <= 80; k++) begin
      @(negedge clk);
      init_req = (k == 10);
      vblank   = !(k >= 20 && k < 30);
      #1;
      if (busy === 1'b1) begin
        busy_cnt++;
        if (bus.a_ready !== 1'b0 || bus.b_ready !== 1'b0) viol++;
      end else begin
        bus.a_valid = 1'b0;
      end
      if (clear_done === 1'b1) begin
        cd_cnt++;
        cd_at = k;
      end
    end
    model_hide_all();
    tests++;
    if (busy_cnt != 64) begin
      fails++;
      $display("FAIL clear_busy_len: got %0d want 64", busy_cnt);
    end
    tests++;
    if (viol != 0) begin
      fails++;
      $display("FAIL clear_ready_low: got %0d ready cycles want 0", viol);
    end
    tests++;
    if (cd_cnt != 1 || cd_at != 65) begin
      fails++;
      $display("FAIL clear_done_pulse: got count=%0d at=%0d want 1 at 65", cd_cnt, cd_at);
    end
    tests++;
    if (board_flat !== model_flat()) begin
      fails++;
      $display("FAIL clear_board: got %h want %h", board_flat, model_flat());
    end
    idle_inputs();
  endtask

  // --------------------------------------------------------------------------
  task automatic test_reset_mid_clear();
    int seen_busy;
    int seen_done;
    seen_busy = 0;
    seen_done = 0;
    @(negedge clk);
    vblank      = 1'b1;
    bus.a_valid = 1'b1;
    bus.a_row   = 3'd7;
    bus.a_col   = 3'd6;
    bus.a_data  = 12'h321;
    @(posedge clk);
    #1;
    model[62] = 12'h321;
    tests++;
    if (board_flat !== model_flat()) begin
      fails++;
      $display("FAIL midclr_prewrite: got %h want %h", board_flat, model_flat());
    end
    @(negedge clk);
    bus.a_valid = 1'b0;
    init_req    = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      init_req = 1'b0;
    end
    reset       = 1'b1;
    bus.a_valid = 1'b1;
    #1;
    model_hide_all();
    tests++;
    if (busy !== 1'b0 || bus.a_ready !== 1'b0) begin
      fails++;
      $display("FAIL midclr_reset: got busy=%b a_ready=%b want 0 0", busy, bus.a_ready);
    end
    tests++;
    if (board_flat !== model_flat()) begin
      fails++;
      $display("FAIL midclr_board: got %h want %h", board_flat, model_flat());
    end
    bus.a_valid = 1'b0;
    @(negedge clk);
    reset  = 1'b0;
    vblank = 1'b0;
    for (int k = 0; k < 70; k++) begin
      @(negedge clk);
      #1;
      if (busy === 1'b1) seen_busy++;
      if (clear_done === 1'b1) seen_done++;
    end
    tests++;
    if (seen_busy != 0 || seen_done != 0) begin
      fails++;
      $display("FAIL midclr_no_resume: got busy=%0d done=%0d want 0 0", seen_busy, seen_done);
    end
    // Reset restores last_grant to B, so A wins a tie.
    @(negedge clk);
    vblank      = 1'b1;
    bus.a_valid = 1'b1; bus.a_row = 3'd3; bus.a_col = 3'd1; bus.a_data = 12'h7E1;
    bus.b_valid = 1'b1; bus.b_row = 3'd0; bus.b_col = 3'd2; bus.b_data = 12'h111;
    #1;
    tests++;
    if ({bus.a_ready, bus.b_ready} !== 2'b10) begin
      fails++;
      $display("FAIL midclr_tie: got %b want 10", {bus.a_ready, bus.b_ready});
    end
    @(posedge clk);
    #1;
    model[25] = 12'h7E1;
    tests++;
    if (board_flat !== model_flat()) begin
      fails++;
      $display("FAIL midclr_write: got %h want %h", board_flat, model_flat());
    end
    @(negedge clk);
    idle_inputs();
  endtask

  // --------------------------------------------------------------------------
  initial begin
    test_reset();
    test_arbitration();
    test_single_write();
    test_b_only();
    test_vblank_hold();
    test_clear();
    test_reset_mid_clear();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
